main_control_fsm: RTL and testbench
===================================

// Module: main_control_fsm
// PURPOSE
//   Multicycle MIPS main control unit: Moore FSM decoding the 6-bit opcode into per-cycle datapath
//   controls. It drives the 2-bit alu_op consumed by the ALU control decoder: 00 add, 01 sub, 10 use funct.
//   Sits between the instruction register opcode field and the shared-memory multicycle datapath.
// PARAMETERS
//   OP_RTYPE  6'b000000  R-type opcode
//   OP_LW     6'b100011  load word
//   OP_SW     6'b101011  store word
//   OP_BEQ    6'b000100  branch if equal
//   OP_ADDI   6'b001000  add immediate
//   OP_J      6'b000010  jump
// PORTS
//   clk            in   1  rising-edge clock
//   reset          in   1  synchronous, active-high reset
//   opcode         in   6  IR[31:26]; valid from DECODE onward
//   pc_write       out  1  unconditional PC write
//   branch         out  1  PC write if ALU zero (datapath ANDs with zero)
//   iord           out  1  memory address select: 0 = PC, 1 = ALUOut
//   mem_write      out  1  memory write enable
//   ir_write       out  1  instruction register load
//   reg_dst        out  1  destination register: 0 = rt, 1 = rd
//   mem_to_reg     out  1  write-back source: 0 = ALUOut, 1 = MDR
//   reg_write      out  1  register file write enable
//   alu_src_a      out  1  ALU A: 0 = PC, 1 = A reg
//   alu_src_b      out  2  ALU B: 00 = B reg, 01 = const 4, 10 = sign-ext imm, 11 = sign-ext imm<<2
//   alu_op         out  2  to ALU control decoder
//   pc_src         out  2  PC source: 00 = ALU result, 01 = ALUOut, 10 = jump target
//   state          out  4  current state encoding (debug)
//   instr_done     out  1  high in the final cycle of each instruction
//   illegal_op     out  1  one-cycle pulse in DECODE when the opcode is unrecognised
// BEHAVIOUR
//   - Registered 4-bit state; all outputs are a combinational function of state (illegal_op also uses opcode).
//   - Every output not listed for a state is 0.
//   - Reset: state <= FETCH at the clock edge.
//     - While reset is high, pc_write, ir_write, reg_write, mem_write, branch, instr_done and illegal_op are forced to 0.
//     - Mux selects take their FETCH values while reset is high.
//     - Reset mid-instruction aborts it with no further writes.
//   States (encoding -> outputs -> next state):
//     0  FETCH:   alu_src_b=01, ir_write=1, pc_write=1 -> DECODE
//     1  DECODE:  alu_src_b=11 -> opcode dispatch:
//                 LW/SW -> MEMADR, RTYPE -> EXECUTE, BEQ -> BRANCH, ADDI -> ADDIEX, J -> JUMP;
//                 other -> FETCH with illegal_op=1 and instr_done=1
//     2  MEMADR:  alu_src_a=1, alu_src_b=10 -> MEMRD if opcode==OP_LW, else MEMWR
//     3  MEMRD:   iord=1 -> MEMWB
//     4  MEMWB:   mem_to_reg=1, reg_write=1, instr_done=1 -> FETCH
//     5  MEMWR:   iord=1, mem_write=1, instr_done=1 -> FETCH
//     6  EXECUTE: alu_src_a=1, alu_op=10 -> ALUWB
//     7  ALUWB:   reg_dst=1, reg_write=1, instr_done=1 -> FETCH
//     8  BRANCH:  alu_src_a=1, alu_op=01, pc_src=01, branch=1, instr_done=1 -> FETCH
//     9  ADDIEX:  alu_src_a=1, alu_src_b=10 -> ADDIWB
//     10 ADDIWB:  reg_write=1, instr_done=1 -> FETCH
//     11 JUMP:    pc_src=10, pc_write=1, instr_done=1 -> FETCH
//     12-15: unreachable; all outputs 0, next state FETCH
//   - alu_op is 00 in every state except EXECUTE (10) and BRANCH (01).
//   - Cycles per instruction, FETCH through last state:
//     LW 5, SW 4, R-type 4, ADDI 4, BEQ 3, J 3, illegal 2.
//   - opcode is sampled only in DECODE and MEMADR. Changes during other states have no effect.
//   - Exactly one of pc_write, branch or neither is high in any cycle. mem_write and reg_write are never high together.
// TESTING
//   1 reset=1 for 3 cycles, then release -> state=0 and write enables 0 while reset is high;
//     first cycle after release: pc_write=1, ir_write=1, alu_src_b=01.
//   2 opcode=6'b100011 -> state sequence 0,1,2,3,4,0; reg_write=1 and mem_to_reg=1 only in state 4; instr_done only in state 4.
//   3 opcode=6'b000000 -> state sequence 0,1,6,7,0; alu_op=10 in state 6; reg_dst=1 and reg_write=1 in state 7.
//   4 opcode=6'b000100 then 6'b000010 -> BEQ: 0,1,8 with branch=1, pc_src=01, alu_op=01; J: 0,1,11 with pc_write=1, pc_src=10.
//   5 opcode=6'b111111 -> 0,1,0; illegal_op=1 for exactly one cycle in state 1; no reg_write or mem_write.
//   6 Assert reset in MEMWR (state 5) during SW -> mem_write=0 that cycle, state=0 next; then opcode=6'b001000 -> 0,1,9,10,0.

Source files
------------

// File: rtl/main_control_fsm_if.sv
// Control bundle between the multicycle MIPS main control FSM and its datapath.
// master: FSM side (drives controls, reads opcode); slave: datapath side.
interface main_control_fsm_if;
  logic [5:0] opcode;
  logic       pc_write;
  logic       branch;
  logic       iord;
  logic       mem_write;
  logic       ir_write;
  logic       reg_dst;
  logic       mem_to_reg;
  logic       reg_write;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic [1:0] pc_src;
  logic [3:0] state;
  logic       instr_done;
  logic       illegal_op;

  modport master (
    input  opcode,
    output pc_write, branch, iord,
    output mem_write, ir_write,
    output reg_dst, mem_to_reg,
    output reg_write, alu_src_a,
    output alu_src_b, alu_op, pc_src,
    output state, instr_done,
    output illegal_op
  );

  modport slave (
    output opcode,
    input  pc_write, branch, iord,
    input  mem_write, ir_write,
    input  reg_dst, mem_to_reg,
    input  reg_write, alu_src_a,
    input  alu_src_b, alu_op, pc_src,
    input  state, instr_done,
    input  illegal_op
  );
endinterface

// File: rtl/main_control_fsm.sv
// Multicycle MIPS main control: Moore FSM turning IR opcode into per-cycle datapath controls.
// Ports: clk, reset (sync, active-high), bus (opcode in; write enables, mux selects, alu_op, state, done/illegal out).
module main_control_fsm #(
  parameter logic [5:0] OP_RTYPE = 6'b000000,
  parameter logic [5:0] OP_LW    = 6'b100011,
  parameter logic [5:0] OP_SW    = 6'b101011,
  parameter logic [5:0] OP_BEQ   = 6'b000100,
  parameter logic [5:0] OP_ADDI  = 6'b001000,
  parameter logic [5:0] OP_J     = 6'b000010
) (
  input  logic                clk,
  input  logic                reset,
  main_control_fsm_if.master  bus
);

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    EXECUTE = 4'd6,
    ALUWB   = 4'd7,
    BRANCH  = 4'd8,
    ADDIEX  = 4'd9,
    ADDIWB  = 4'd10,
    JUMP    = 4'd11
  } state_t;

  state_t state_q;
  state_t state_d;

  logic is_rtype;
  logic is_mem;
  logic is_beq;
  logic is_addi;
  logic is_j;

  logic       pc_write;
  logic       branch;
  logic       iord;
  logic       mem_write;
  logic       ir_write;
  logic       reg_dst;
  logic       mem_to_reg;
  logic       reg_write;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic [1:0] pc_src;
  logic       instr_done;
  logic       illegal_op;

  assign is_rtype = (bus.opcode == OP_RTYPE);
  assign is_beq   = (bus.opcode == OP_BEQ);
  assign is_addi  = (bus.opcode == OP_ADDI);
  assign is_j     = (bus.opcode == OP_J);
  assign is_mem   = (bus.opcode == OP_LW) ||
                    (bus.opcode == OP_SW);

  always_ff @(posedge clk) begin
    if (reset) state_q <= FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d    = FETCH;
    pc_write   = 1'b0;
    branch     = 1'b0;
    iord       = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    pc_src     = 2'b00;
    instr_done = 1'b0;
    illegal_op = 1'b0;

    case (state_q)
      FETCH: begin
        alu_src_b = 2'b01;
        ir_write  = 1'b1;
        pc_write  = 1'b1;
        state_d   = DECODE;
      end
      DECODE: begin
        alu_src_b = 2'b11;
        unique case (1'b1)
          is_mem:   state_d = MEMADR;
          is_rtype: state_d = EXECUTE;
          is_beq:   state_d = BRANCH;
          is_addi:  state_d = ADDIEX;
          is_j:     state_d = JUMP;
          default: begin
            state_d    = FETCH;
            illegal_op = 1'b1;
            instr_done = 1'b1;
          end
        endcase
      end
      MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = (bus.opcode == OP_LW) ?
                    MEMRD : MEMWR;
      end
      MEMRD: begin
        iord    = 1'b1;
        state_d = MEMWB;
      end
      MEMWB: begin
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      MEMWR: begin
        iord       = 1'b1;
        mem_write  = 1'b1;
        instr_done = 1'b1;
      end
      EXECUTE: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
        state_d   = ALUWB;
      end
      ALUWB: begin
        reg_dst    = 1'b1;
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      BRANCH: begin
        alu_src_a  = 1'b1;
        alu_op     = 2'b01;
        pc_src     = 2'b01;
        branch     = 1'b1;
        instr_done = 1'b1;
      end
      ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = ADDIWB;
      end
      ADDIWB: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      JUMP: begin
        pc_src     = 2'b10;
        pc_write   = 1'b1;
        instr_done = 1'b1;
      end
      default: state_d = FETCH;
    endcase

    // Reset wins over the current state: no writes escape an
    // aborted instruction and the muxes sit at their FETCH values.
    if (reset) begin
      pc_write   = 1'b0;
      branch     = 1'b0;
      iord       = 1'b0;
      mem_write  = 1'b0;
      ir_write   = 1'b0;
      reg_dst    = 1'b0;
      mem_to_reg = 1'b0;
      reg_write  = 1'b0;
      alu_src_a  = 1'b0;
      alu_src_b  = 2'b01;
      alu_op     = 2'b00;
      pc_src     = 2'b00;
      instr_done = 1'b0;
      illegal_op = 1'b0;
    end
  end

  assign bus.pc_write   = pc_write;
  assign bus.branch     = branch;
  assign bus.iord       = iord;
  assign bus.mem_write  = mem_write;
  assign bus.ir_write   = ir_write;
  assign bus.reg_dst    = reg_dst;
  assign bus.mem_to_reg = mem_to_reg;
  assign bus.reg_write  = reg_write;
  assign bus.alu_src_a  = alu_src_a;
  assign bus.alu_src_b  = alu_src_b;
  assign bus.alu_op     = alu_op;
  assign bus.pc_src     = pc_src;
  assign bus.state      = state_q;
  assign bus.instr_done = instr_done;
  assign bus.illegal_op = illegal_op;

endmodule

// File: tb/tb_main_control_fsm.sv
// Self-checking bench for main_control_fsm: directed scenarios plus random
// opcode/reset traffic checked against an instruction-level reference model.
module tb_main_control_fsm;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  typedef struct packed {
    logic       pc_write;
    logic       branch;
    logic       iord;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_src;
    logic       instr_done;
    logic       illegal_op;
  } ctl_t;

  logic clk = 1'b0;
  logic reset;
  int   passed = 0;
  int   total  = 0;

  main_control_fsm_if bus ();

  main_control_fsm dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic bit is_legal(input logic [5:0] op);
    return op == OP_RTYPE || op == OP_LW ||
           op == OP_SW || op == OP_BEQ ||
           op == OP_ADDI || op == OP_J;
  endfunction

  // Expected outputs for cycle k (0 = fetch) of instruction op.
  function automatic void exp_step(
    input  logic [5:0] op,
    input  int         k,
    output ctl_t       c,
    output logic [3:0] st,
    output bit         last
  );
    c = '0; st = 4'd0; last = 1'b0;
    if (k == 0) begin
      c.ir_write = 1; c.pc_write = 1;
      c.alu_src_b = 2'b01;
    end else if (k == 1) begin
      st = 4'd1; c.alu_src_b = 2'b11;
      if (!is_legal(op)) begin
        c.illegal_op = 1; c.instr_done = 1;
        last = 1;
      end
    end else if (op == OP_LW || op == OP_SW) begin
      if (k == 2) begin
        st = 4'd2; c.alu_src_a = 1;
        c.alu_src_b = 2'b10;
      end else if (op == OP_SW) begin
        st = 4'd5; c.iord = 1; c.mem_write = 1;
        c.instr_done = 1; last = 1;
      end else if (k == 3) begin
        st = 4'd3; c.iord = 1;
      end else begin
        st = 4'd4; c.mem_to_reg = 1;
        c.reg_write = 1; c.instr_done = 1;
        last = 1;
      end
    end else if (op == OP_RTYPE) begin
      if (k == 2) begin
        st = 4'd6; c.alu_src_a = 1;
        c.alu_op = 2'b10;
      end else begin
        st = 4'd7; c.reg_dst = 1;
        c.reg_write = 1; c.instr_done = 1;
        last = 1;
      end
    end else if (op == OP_BEQ) begin
      st = 4'd8; c.alu_src_a = 1;
      c.alu_op = 2'b01; c.pc_src = 2'b01;
      c.branch = 1; c.instr_done = 1;
      last = 1;
    end else if (op == OP_ADDI) begin
      if (k == 2) begin
        st = 4'd9; c.alu_src_a = 1;
        c.alu_src_b = 2'b10;
      end else begin
        st = 4'd10; c.reg_write = 1;
        c.instr_done = 1; last = 1;
      end
    end else begin
      st = 4'd11; c.pc_src = 2'b10;
      c.pc_write = 1; c.instr_done = 1;
      last = 1;
    end
  endfunction

  function automatic ctl_t reset_ctl();
    ctl_t c;
    c = '0;
    c.alu_src_b = 2'b01;
    return c;
  endfunction

  function automatic ctl_t obs();
    ctl_t c;
    c.pc_write   = bus.pc_write;
    c.branch     = bus.branch;
    c.iord       = bus.iord;
    c.mem_write  = bus.mem_write;
    c.ir_write   = bus.ir_write;
    c.reg_dst    = bus.reg_dst;
    c.mem_to_reg = bus.mem_to_reg;
    c.reg_write  = bus.reg_write;
    c.alu_src_a  = bus.alu_src_a;
    c.alu_src_b  = bus.alu_src_b;
    c.alu_op     = bus.alu_op;
    c.pc_src     = bus.pc_src;
    c.instr_done = bus.instr_done;
    c.illegal_op = bus.illegal_op;
    return c;
  endfunction

  // Advance one clock, apply inputs, settle to the sampling edge.
  task automatic drive(input logic r,
                       input logic [5:0] op);
    @(posedge clk);
    #1;
    reset = r;
    bus.opcode = op;
    @(negedge clk);
  endtask

  task automatic test_reset();
    ctl_t e, o;
    logic [3:0] st;
    bit last;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 6'($urandom));
      total++;
      if (bus.state !== 4'd0)
        $display("FAIL rst_state cyc%0d: got %0d want 0",
                 i, bus.state);
      else passed++;
      o = obs();
      total++;
      if (o !== reset_ctl())
        $display("FAIL rst_ctl cyc%0d: got %h want %h",
                 i, o, reset_ctl());
      else passed++;
    end
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, k == 0 ? 6'($urandom) : OP_J);
      exp_step(OP_J, k, e, st, last);
      o = obs();
      total++;
      if (bus.state !== st || o !== e)
        $display("FAIL rst_release k%0d: got st%0d %h want st%0d %h",
                 k, bus.state, o, st, e);
      else passed++;
    end
  endtask

  task automatic test_opcode(input logic [5:0] op,
                             input int cpi);
    ctl_t e, o;
    logic [3:0] st;
    bit last;
    int k;
    k = 0;
    last = 1'b0;
    while (!last && k < 8) begin
      drive(1'b0, (k == 1 || k == 2) ?
            op : 6'($urandom));
      exp_step(op, k, e, st, last);
      o = obs();
      total++;
      if (bus.state !== st)
        $display("FAIL op%b_state k%0d: got %0d want %0d",
                 op, k, bus.state, st);
      else passed++;
      total++;
      if (o !== e)
        $display("FAIL op%b_ctl k%0d: got %h want %h",
                 op, k, o, e);
      else passed++;
      k++;
    end
    total++;
    if (k !== cpi)
      $display("FAIL op%b_cpi: got %0d want %0d",
               op, k, cpi);
    else passed++;
  endtask

  task automatic test_reset_abort();
    ctl_t e, o;
    logic [3:0] st;
    bit last;
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, k == 0 ? 6'($urandom) : OP_SW);
      exp_step(OP_SW, k, e, st, last);
      o = obs();
      total++;
      if (bus.state !== st || o !== e)
        $display("FAIL abort_sw k%0d: got st%0d %h want st%0d %h",
                 k, bus.state, o, st, e);
      else passed++;
    end
    drive(1'b1, OP_SW);
    total++;
    if (bus.state !== 4'd5 || bus.mem_write !== 1'b0)
      $display("FAIL abort_memwr: got st%0d mw%b want st5 mw0",
               bus.state, bus.mem_write);
    else passed++;
    o = obs();
    total++;
    if (o !== reset_ctl())
      $display("FAIL abort_ctl: got %h want %h",
               o, reset_ctl());
    else passed++;
    test_opcode(OP_ADDI, 4);
  endtask

  task automatic test_random(input int cycles);
    logic [5:0] legal [6];
    logic [5:0] cur;
    ctl_t e, o;
    logic [3:0] st;
    bit last, r;
    int k;
    legal = '{OP_RTYPE, OP_LW, OP_SW,
              OP_BEQ, OP_ADDI, OP_J};
    k = 0;
    cur = OP_J;
    for (int n = 0; n < cycles; n++) begin
      if (k == 0)
        cur = ($urandom_range(0, 4) == 0) ?
              6'($urandom) : legal[$urandom_range(0, 5)];
      r = ($urandom_range(0, 19) == 0);
      drive(r, (k == 1 || k == 2) ?
            cur : 6'($urandom));
      exp_step(cur, k, e, st, last);
      if (r) e = reset_ctl();
      o = obs();
      total++;
      if (bus.state !== st)
        $display("FAIL rnd_state n%0d: got %0d want %0d",
                 n, bus.state, st);
      else passed++;
      total++;
      if (o !== e)
        $display("FAIL rnd_ctl n%0d op%b k%0d: got %h want %h",
                 n, cur, k, o, e);
      else passed++;
      total++;
      if ((o.pc_write && o.branch) ||
          (o.mem_write && o.reg_write))
        $display("FAIL rnd_excl n%0d: got %h want exclusive enables",
                 n, o);
      else passed++;
      k = (r || last) ? 0 : k + 1;
    end
  endtask

  initial begin
    reset = 1'b1;
    bus.opcode = 6'd0;
    test_reset();
    test_opcode(OP_LW, 5);
    test_opcode(OP_RTYPE, 4);
    test_opcode(OP_BEQ, 3);
    test_opcode(OP_J, 3);
    test_opcode(6'b111111, 2);
    test_opcode(OP_SW, 4);
    test_reset_abort();
    test_random(600);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
